// File: rtl/m_uart.sv
// m_uart: 8N1/8N2 UART with independent receive and transmit paths.
// RX oversamples at mid-bit; TX holds each bit CLKS_PER_BIT cycles.
module m_uart #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_frame_err,
    output logic       uart_tx,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LP_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LP_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic          LP_SLAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx;

    state_t        r_rx_st;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic          r_rx_stop;
    logic          r_rx_bad;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_done;
    logic          r_rx_err;

    state_t        r_tx_st;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic          r_tx_stop;
    logic [7:0]    r_tx_shift;
    logic          r_tx;
    logic          r_tx_busy;
    logic          r_tx_done;

    assign w_rx         = r_sync2;
    assign rx_data      = r_rx_data;
    assign rx_done      = r_rx_done;
    assign rx_frame_err = r_rx_err;
    assign uart_tx      = r_tx;
    assign tx_busy      = r_tx_busy;
    assign tx_done      = r_tx_done;

    // Two-flop synchronizer for the asynchronous receive line, idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM: confirm start at mid-bit, then sample once per bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_st    <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_stop  <= 1'b0;
            r_rx_bad   <= 1'b0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_done  <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            r_rx_err  <= 1'b0;
            unique case (r_rx_st)
                S_IDLE: begin
                    r_rx_cnt <= '0;
                    if (!w_rx) begin
                        r_rx_st <= S_START;
                    end
                end
                S_START: begin
                    if (r_rx_cnt == LP_HALF) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_st  <= w_rx ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_rx_cnt == LP_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_stop <= 1'b0;
                            r_rx_bad  <= 1'b0;
                            r_rx_st   <= S_STOP;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_rx_cnt == LP_LAST) begin
                        r_rx_cnt <= '0;
                        if (r_rx_stop == LP_SLAST) begin
                            // Back to idle at once so a close next start is caught.
                            r_rx_st <= S_IDLE;
                            if (w_rx && !r_rx_bad) begin
                                r_rx_data <= r_rx_shift;
                                r_rx_done <= 1'b1;
                            end else begin
                                r_rx_err <= 1'b1;
                            end
                        end else begin
                            r_rx_stop <= 1'b1;
                            r_rx_bad  <= !w_rx;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_st <= S_IDLE;
            endcase
        end
    end

    // Transmit FSM: shifts the captured byte out LSB first, can chain frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_st    <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            unique case (r_tx_st)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_tx_busy <= 1'b0;
                    r_tx_cnt  <= '0;
                    if (tx_start) begin
                        r_tx_shift <= tx_data;
                        r_tx_busy  <= 1'b1;
                        r_tx       <= 1'b0;
                        r_tx_st    <= S_START;
                    end
                end
                S_START: begin
                    if (r_tx_cnt == LP_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_st    <= S_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tx_cnt == LP_LAST) begin
                        r_tx_cnt <= '0;
                        r_tx_bit <= r_tx_bit + 1'b1;
                        if (r_tx_bit == 3'd7) begin
                            r_tx      <= 1'b1;
                            r_tx_stop <= 1'b0;
                            r_tx_st   <= S_STOP;
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tx_stop == LP_SLAST && r_tx_cnt == LP_PRE) begin
                        r_tx_done <= 1'b1;
                    end
                    if (r_tx_cnt == LP_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_stop == LP_SLAST) begin
                            // A start in the done cycle chains with no idle gap.
                            if (tx_start) begin
                                r_tx_shift <= tx_data;
                                r_tx       <= 1'b0;
                                r_tx_st    <= S_START;
                            end else begin
                                r_tx_busy <= 1'b0;
                                r_tx_st   <= S_IDLE;
                            end
                        end else begin
                            r_tx_stop <= 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_uart.sv
// tb_m_uart: scoreboard bench for m_uart, RX/TX decoded by
// independent monitors against queued expectations.
module tb_m_uart;

    localparam int CPB   = 8;
    localparam int SB    = 1;
    localparam int FRAME = (9 + SB) * CPB;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       uart_rx  = 1'b1;
    logic       tb_start = 1'b0;
    logic [7:0] tb_data  = 8'h00;
    logic       loop_en  = 1'b0;

    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_frame_err;
    logic       uart_tx;
    logic       tx_busy;
    logic       tx_done;
    logic       dut_tx_start;
    logic [7:0] dut_tx_data;

    assign dut_tx_start = loop_en ? rx_done : tb_start;
    assign dut_tx_data  = loop_en ? rx_data : tb_data;

    m_uart #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .rx_frame_err (rx_frame_err),
        .uart_tx      (uart_tx),
        .tx_start     (dut_tx_start),
        .tx_data      (dut_tx_data),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rx_exp_t;

    rx_exp_t    rx_q[$];
    logic [7:0] tx_q[$];
    int         n_tests     = 0;
    int         n_fail      = 0;
    int         rx_done_cnt = 0;
    int         tx_done_cnt = 0;
    logic [7:0] last_good   = 8'h00;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_ok);
        rx_exp_t e;
        e.err  = !stop_ok;
        e.data = stop_ok ? b : last_good;
        if (stop_ok) last_good = b;
        rx_q.push_back(e);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        for (int s = 0; s < SB; s++) begin
            uart_rx = stop_ok;
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    // RX monitor: every done/error pulse is matched against the queue head.
    rx_exp_t rx_e;
    always @(negedge clk) begin
        if (!rst && (rx_done || rx_frame_err)) begin
            if (rx_done) rx_done_cnt++;
            if (rx_q.size() == 0) begin
                chk("rx_unexpected_event", {30'd0, rx_done, rx_frame_err}, 32'd0);
            end else begin
                rx_e = rx_q.pop_front();
                chk("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, rx_e.err});
                chk("rx_done", {31'd0, rx_done}, {31'd0, !rx_e.err});
                chk("rx_data", {24'd0, rx_data}, {24'd0, rx_e.data});
            end
        end
    end

    // TX monitor: decodes uart_tx at mid-bit and compares whole bytes.
    logic       mon_act = 1'b0;
    int         mon_t   = 0;
    int         mon_k   = 0;
    logic [7:0] mon_byte;
    always @(negedge clk) begin
        if (tx_done) tx_done_cnt++;
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (!uart_tx) begin
                mon_act = 1'b1;
                mon_t   = 0;
            end
        end else begin
            mon_t++;
            if (mon_t % CPB == CPB / 2) begin
                mon_k = mon_t / CPB;
                if (mon_k == 0) begin
                    chk("tx_start_bit", {31'd0, uart_tx}, 32'd0);
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = uart_tx;
                end else begin
                    chk("tx_stop_bit", {31'd0, uart_tx}, 32'd1);
                    if (mon_k == 8 + SB) begin
                        mon_act = 1'b0;
                        if (tx_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL tx_unexpected_frame: got %0h expected none",
                                     mon_byte);
                        end else begin
                            chk("tx_byte", {24'd0, mon_byte}, {24'd0, tx_q.pop_front()});
                        end
                    end
                end
            end
        end
    end

    logic bad;
    int   n;
    int   c0;
    int   c1;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_done", {31'd0, rx_done}, 32'd0);
        chk("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);
        chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || rx_done || rx_frame_err) bad = 1'b1;
        end
        chk("idle_quiet", {31'd0, bad}, 32'd0);

        send_rx(8'h55, 1'b1);
        send_rx(8'hA3, 1'b1);
        repeat (20) @(negedge clk);
        send_rx(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        chk("rx_data_after_err", {24'd0, rx_data}, 32'h0000_00A3);

        c0 = rx_done_cnt;
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_no_rx", c0, rx_done_cnt);
        chk("rx_done_count_directed", rx_done_cnt, 32'd2);

        c1 = tx_done_cnt;
        tb_data  = 8'hA5;
        tb_start = 1'b1;
        tx_q.push_back(8'hA5);
        @(negedge clk);
        tb_start = 1'b0;
        tb_data  = 8'h00;
        chk("tx_busy_on_start", {31'd0, tx_busy}, 32'd1);
        chk("tx_line_low_on_start", {31'd0, uart_tx}, 32'd0);
        n = 1;
        while (!tx_done && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 20) begin
                tb_start = 1'b1;
                tb_data  = 8'h3C;
            end
            if (n == 21) tb_start = 1'b0;
        end
        chk("tx_frame_len", n, FRAME);
        tb_start = 1'b1;
        tb_data  = 8'h5A;
        tx_q.push_back(8'h5A);
        @(negedge clk);
        tb_start = 1'b0;
        tb_data  = 8'hFF;
        chk("tx_b2b_busy", {31'd0, tx_busy}, 32'd1);
        chk("tx_b2b_line_low", {31'd0, uart_tx}, 32'd0);
        n = 1;
        while (!tx_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tx_b2b_frame_len", n, FRAME);
        @(negedge clk);
        chk("tx_busy_after_done", {31'd0, tx_busy}, 32'd0);
        chk("tx_idle_after_done", {31'd0, uart_tx}, 32'd1);
        chk("tx_done_count_directed", tx_done_cnt - c1, 32'd2);
        repeat (20) @(negedge clk);

        loop_en = 1'b1;
        c0 = rx_done_cnt;
        c1 = tx_done_cnt;
        for (int i = 0; i < 200; i++) begin
            tb_data = (i % 2 == 0) ? 8'hFF : 8'h00;
            tx_q.push_back(tb_data);
            send_rx(tb_data, 1'b1);
        end
        repeat (200) @(negedge clk);
        loop_en = 1'b0;
        chk("loop_rx_done_count", rx_done_cnt - c0, 32'd200);
        chk("loop_tx_done_count", tx_done_cnt - c1, 32'd200);

        c1 = tx_done_cnt;
        tb_data  = 8'h81;
        tb_start = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx_line", {31'd0, uart_tx}, 32'd1);
        chk("rst_mid_tx_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_rx_data_clear", {24'd0, rx_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        repeat (120) @(negedge clk);
        chk("rst_mid_tx_no_done", tx_done_cnt - c1, 32'd0);
        chk("rst_mid_tx_idle", {31'd0, uart_tx}, 32'd1);

        n = 0;
        while ((rx_q.size() != 0 || tx_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("queues_drained", rx_q.size() + tx_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
